// File: rtl/fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_pkg
//   Shared definitions for the fetch front end: FSM state encoding, the
//   opcode bit that flags a two-word instruction, the bubble word and the
//   default boot/interrupt vector locations.
// ---------------------------------------------------------------------------
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,   // load PC from the word at the reset vector
        RUN  = 2'd1,   // normal opcode fetch
        IMM  = 2'd2,   // next word is the immediate of the current opcode
        INTV = 2'd3    // load PC from the word at the interrupt vector
    } fetch_state_e;

    // Opcode bit that announces a trailing immediate word.
    localparam int unsigned IMM_FLAG_BIT = 2;

    // Instruction-register contents when nothing has been fetched yet.
    localparam logic [15:0] BUBBLE_WORD = 16'h0000;

    // Default word addresses holding the boot PC and the ISR address.
    localparam int unsigned RESET_VEC_DEFAULT = 0;
    localparam int unsigned INT_VEC_DEFAULT   = 1;

endpackage : fetch_sequencer_pkg

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Front end of the pipelined core. Owns the PC, drives the instruction
//   memory address, and registers the fetched word stream for decode. Tracks
//   two-word instructions (opcode + immediate), applies stalls, jumps and
//   interrupts at word boundaries, and boots from a memory-resident vector.
//
// Ports
//   clk           core clock, rising edge
//   rst           synchronous active-high reset
//   imemAddr      instruction-memory word address (always equals the PC)
//   imemData      word read from imemAddr, valid in the same cycle
//   stall         hold PC and all fetch outputs
//   jumpBit       taken control transfer resolved downstream
//   jumpTarget    new PC when jumpBit is set
//   interruptBit  level-sensitive interrupt request
//   iR            registered word for decode
//   iRValid       iR holds a real fetched word (0 = bubble)
//   iRIsImm       iR is the immediate of the preceding opcode
//   iRPc          address iR was fetched from
//   intAck        one-cycle pulse when an interrupt is taken
//   intRetPc      return PC for the ISR entry logic, valid with intAck
// ---------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 20,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEFAULT),
    parameter logic [ADDR_W-1:0] INT_VEC   = ADDR_W'(INT_VEC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic [15:0]       imemData,
    input  logic              stall,
    input  logic              jumpBit,
    input  logic [ADDR_W-1:0] jumpTarget,
    input  logic              interruptBit,
    output logic [15:0]       iR,
    output logic              iRValid,
    output logic              iRIsImm,
    output logic [ADDR_W-1:0] iRPc,
    output logic              intAck,
    output logic [ADDR_W-1:0] intRetPc
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              ir_is_imm_q, ir_is_imm_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              int_ack_q, int_ack_d;
    logic [ADDR_W-1:0] int_ret_pc_q, int_ret_pc_d;

    // Vector words are 16-bit; the upper PC bits are zero-extended.
    logic [ADDR_W-1:0] vector_pc;
    assign vector_pc = ADDR_W'(imemData);

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a hold/default value first, so no path
        // through the branches below can leave it unassigned and infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        ir_valid_d   = ir_valid_q;
        ir_is_imm_d  = ir_is_imm_q;
        ir_pc_d      = ir_pc_q;
        int_ack_d    = 1'b0;
        int_ret_pc_d = int_ret_pc_q;

        if (state_q == BOOT) begin
            // Boot ignores stall, jump and interrupt.
            pc_d        = vector_pc;
            ir_valid_d  = 1'b0;
            ir_is_imm_d = 1'b0;
            state_d     = RUN;
        end else if (jumpBit) begin
            // Jump outranks stall and interrupt and drops a pending immediate
            // or an in-flight vector load.
            pc_d        = jumpTarget;
            ir_valid_d  = 1'b0;
            ir_is_imm_d = 1'b0;
            state_d     = RUN;
        end else if (!stall) begin
            case (state_q)
                RUN: begin
                    if (interruptBit) begin
                        // Take the interrupt instead of fetching; the PC that
                        // would have been fetched is the return address.
                        int_ack_d    = 1'b1;
                        int_ret_pc_d = pc_q;
                        ir_valid_d   = 1'b0;
                        ir_is_imm_d  = 1'b0;
                        pc_d         = INT_VEC;
                        state_d      = INTV;
                    end else begin
                        ir_d        = imemData;
                        ir_pc_d     = pc_q;
                        ir_valid_d  = 1'b1;
                        ir_is_imm_d = 1'b0;
                        pc_d        = pc_q + ADDR_W'(1);
                        if (imemData[IMM_FLAG_BIT]) begin
                            state_d = IMM;
                        end
                    end
                end
                IMM: begin
                    // The immediate completes an atomic pair; interrupts wait.
                    ir_d        = imemData;
                    ir_pc_d     = pc_q;
                    ir_valid_d  = 1'b1;
                    ir_is_imm_d = 1'b1;
                    pc_d        = pc_q + ADDR_W'(1);
                    state_d     = RUN;
                end
                INTV: begin
                    pc_d        = vector_pc;
                    ir_valid_d  = 1'b0;
                    ir_is_imm_d = 1'b0;
                    state_d     = RUN;
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VEC;
            ir_q         <= BUBBLE_WORD;
            ir_valid_q   <= 1'b0;
            ir_is_imm_q  <= 1'b0;
            ir_pc_q      <= '0;
            int_ack_q    <= 1'b0;
            int_ret_pc_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            ir_valid_q   <= ir_valid_d;
            ir_is_imm_q  <= ir_is_imm_d;
            ir_pc_q      <= ir_pc_d;
            int_ack_q    <= int_ack_d;
            int_ret_pc_q <= int_ret_pc_d;
        end
    end

    assign imemAddr = pc_q;
    assign iR       = ir_q;
    assign iRValid  = ir_valid_q;
    assign iRIsImm  = ir_is_imm_q;
    assign iRPc     = ir_pc_q;
    assign intAck   = int_ack_q;
    assign intRetPc = int_ret_pc_q;

endmodule : fetch_sequencer

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front end of the pipelined core. Owns the PC, drives the instruction-memory address and supplies the fetch-stage word stream to the IR detector / decode stage.
- Tracks two-word instructions: a word with bit 2 = 1 is followed by an immediate word. That immediate word is tagged and is never itself decoded as an opcode.
- Applies stalls, jumps and interrupts at word boundaries, and boots the PC from a memory-resident reset vector.

Parameters:
- ADDR_W, 20, instruction-memory word-address width (PC width).
- RESET_VEC, 0, word address holding the boot PC (low 16 bits; upper bits zero-extended).
- INT_VEC, 1, word address holding the interrupt service routine address.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imemAddr  out  ADDR_W  word address to instruction memory; read data returns combinationally in the same cycle.
- imemData  in  16  word read from imemAddr.
- stall  in  1  hold PC and outputs (hazard unit).
- jumpBit  in  1  taken jump/branch/call/ret resolved downstream.
- jumpTarget  in  ADDR_W  new PC when jumpBit = 1.
- interruptBit  in  1  level interrupt request.
- iR  out  16  registered word to the decode stage.
- iRValid  out  1  iR holds a real fetched word; 0 means bubble.
- iRIsImm  out  1  iR is the immediate of the preceding instruction.
- iRPc  out  ADDR_W  address iR was fetched from.
- intAck  out  1  one-cycle pulse when the interrupt is taken.
- intRetPc  out  ADDR_W  PC to be pushed by the ISR-entry logic; valid with intAck.

Behaviour:
- Reset, while rst = 1 on an edge:
  - state = BOOT, pc = RESET_VEC, imemAddr = RESET_VEC.
  - iR = 0, iRValid = 0, iRIsImm = 0, iRPc = 0, intAck = 0, intRetPc = 0.
  - Reset asserted mid-operation discards any pending immediate or interrupt.
- States: BOOT, RUN, IMM, INTV.
- BOOT:
  - One cycle. pc <= zero-extended imemData (the word read at RESET_VEC). iRValid <= 0.
  - Next state is RUN. stall, jump and interrupt are ignored.
- RUN, with stall = 0:
  - iR <= imemData, iRPc <= pc, iRValid <= 1, iRIsImm <= 0, pc <= pc + 1.
  - If imemData[2] = 1, go to IMM.
- IMM, with stall = 0:
  - iR <= imemData, iRIsImm <= 1, iRValid <= 1, pc <= pc + 1, then go to RUN.
  - An instruction and its immediate are an atomic pair: interrupts are not taken in IMM.
- Jump (jumpBit = 1, any state except BOOT; takes priority over stall and interrupt):
  - pc <= jumpTarget, iRValid <= 0, iRIsImm <= 0, state <= RUN.
  - A pending immediate is dropped.
  - Latency: the target word appears on iR two edges after jumpBit is sampled.
- Interrupt (interruptBit = 1 in RUN with stall = 0 and jumpBit = 0):
  - Do not fetch. intAck <= 1, intRetPc <= pc, iRValid <= 0, pc <= INT_VEC, state <= INTV.
- INTV:
  - pc <= zero-extended imemData (the word read at INT_VEC), iRValid <= 0, state <= RUN.
  - interruptBit is ignored until back in RUN. It is level-sensitive: the source must drop it after intAck, or it is retaken.
- Stall = 1 with no jump: pc, state, iR, iRValid, iRIsImm and iRPc all hold. intAck is forced to 0.
- imemAddr = pc at all times.
- PC arithmetic wraps modulo 2^ADDR_W: pc = all-ones increments to 0, and a pending immediate is then fetched from address 0.
- intAck is high for exactly one cycle per interrupt taken.

Decomposition:
- Shared package (processor-wide `define file):
  - state encodings BOOT = 2'd0, RUN = 2'd1, IMM = 2'd2, INTV = 2'd3;
  - IMM_FLAG_BIT = 2;
  - BUBBLE_WORD = 16'h0000;
  - RESET_VEC and INT_VEC defaults.
- Single module with no sub-module. The PC register plus next-PC mux is small enough to stay inline.

Test Plan:
1. Reset boot: mem[0] = 16'h0010, rst for 2 cycles → BOOT 1 cycle with iRValid = 0, then iRPc = 0x10 and iR = mem[0x10].
2. Immediate pair: mem[0x10] = 16'h0004, mem[0x11] = 16'hBEEF → iR = 0004 (iRIsImm = 0), then BEEF (iRIsImm = 1), then mem[0x12] with iRIsImm = 0.
3. Jump during IMM: jumpBit = 1, jumpTarget = 0x40 while in IMM → immediate dropped, one bubble, then iR = mem[0x40], iRIsImm = 0.
4. Interrupt: interruptBit = 1 in RUN at pc = 0x13, mem[1] = 16'h0200 → intAck pulse with intRetPc = 0x13, two bubbles, then iRPc = 0x200.
5. Interrupt deferred in IMM: interrupt asserted the same cycle the immediate is fetched → the immediate is delivered first, then intAck fires with intRetPc = address after the immediate.
6. Stall and wrap: stall for 3 cycles → all outputs frozen. Set pc to all-ones via a jump with a bit-2 word there → immediate fetched from address 0.
